// File: rtl/dpll_recovery.sv
// Digital PLL bit-clock recovery: oversampled line in, bit strobe, mid-bit data and lock out.
// Bang-bang +/-1 count phase correction per bit with deadband and an edge-count lock detector.
module dpll_recovery #(
    parameter int OSR        = 16,
    parameter int DEADBAND   = 0,
    parameter int LOCK_COUNT = 8,
    parameter int PW         = $clog2(OSR) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          sync_in,
    output logic          clken_out,
    output logic          data_out,
    output logic          data_valid,
    output logic          locked,
    output logic [PW-1:0] phase_err
);

    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] PH_LAST  = CW'(OSR - 1);
    localparam logic [CW-1:0] PH_SHORT = CW'(OSR - 2);
    localparam logic [CW-1:0] PH_MID   = CW'(OSR / 2);

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_LONG  = 2'd1,
        PEND_SHORT = 2'd2
    } pend_t;

    logic          r_sync1;
    logic          r_sync_s;
    logic          r_prev;
    logic [CW-1:0] r_ph;
    pend_t         r_pend;
    logic          r_held;
    logic          r_seen;
    logic [7:0]    r_lock_cnt;
    logic          r_locked;
    logic          r_data;
    logic          r_valid;
    logic [PW-1:0] r_perr;

    logic                 w_edge;
    logic                 w_eval;
    logic                 w_short;
    logic                 w_hold;
    logic                 w_wrap;
    logic                 w_end;
    logic                 w_consume;
    logic signed [PW-1:0] w_err;
    logic [PW-1:0]        w_err_u;
    logic [PW-1:0]        w_abs;
    logic                 w_in_band;
    logic                 w_far;
    logic [7:0]           w_lock_next;

    // Synchroniser and edge flop keep running while disabled so re-enable sees a settled line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync_s <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_sync1  <= sync_in;
            r_sync_s <= r_sync1;
            r_prev   <= r_sync_s;
        end
    end

    assign w_edge    = r_sync_s ^ r_prev;
    assign w_eval    = w_edge & ~r_seen;
    assign w_short   = (r_pend == PEND_SHORT) && (r_ph == PH_SHORT);
    assign w_hold    = (r_pend == PEND_LONG) && (r_ph == PH_LAST) && !r_held;
    assign w_wrap    = (r_ph == PH_LAST) && !w_hold;
    assign w_end     = w_short | w_wrap;
    assign w_consume = w_short | (w_wrap & r_held);

    // Phase folded into [-OSR/2, OSR/2-1]; positive means the counter runs ahead of the line.
    assign w_err     = (r_ph < PH_MID) ? $signed({1'b0, r_ph})
                                       : $signed({1'b0, r_ph} - PW'(OSR));
    assign w_err_u   = w_err;
    assign w_abs     = w_err_u[PW-1] ? (~w_err_u + PW'(1)) : w_err_u;
    assign w_in_band = (w_abs <= PW'(DEADBAND));
    assign w_far     = (w_abs >= PW'(OSR / 4));
    assign w_lock_next = (r_lock_cnt == 8'hFF) ? r_lock_cnt : (r_lock_cnt + 8'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph       <= '0;
            r_pend     <= PEND_NONE;
            r_held     <= 1'b0;
            r_seen     <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_locked   <= 1'b0;
            r_data     <= 1'b0;
            r_valid    <= 1'b0;
            r_perr     <= '0;
        end else if (!enable) begin
            r_ph       <= '0;
            r_pend     <= PEND_NONE;
            r_held     <= 1'b0;
            r_seen     <= 1'b0;
            r_lock_cnt <= 8'd0;
            r_locked   <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_end) begin
                r_ph <= '0;
            end else if (!w_hold) begin
                r_ph <= r_ph + CW'(1);
            end
            r_held <= w_hold;
            r_seen <= w_end ? 1'b0 : (r_seen | w_edge);

            r_valid <= (r_ph == PH_MID);
            if (r_ph == PH_MID) begin
                r_data <= r_sync_s;
            end

            // A correction found on this very cycle outranks clearing the one just consumed.
            if (w_eval && !w_in_band) begin
                r_pend <= w_err_u[PW-1] ? PEND_SHORT : PEND_LONG;
            end else if (w_consume) begin
                r_pend <= PEND_NONE;
            end

            if (w_eval) begin
                r_perr <= w_err_u;
                if (w_in_band) begin
                    r_lock_cnt <= w_lock_next;
                    r_locked   <= (w_lock_next >= 8'(LOCK_COUNT));
                end else if (w_far) begin
                    r_lock_cnt <= 8'd0;
                    r_locked   <= 1'b0;
                end
            end
        end
    end

    assign clken_out  = enable & w_end;
    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign locked     = r_locked;
    assign phase_err  = r_perr;

endmodule
